rr_mux4: RTL and testbench

RR_MUX4 -- requirements
Module: rr_mux4

---
 rtl/rr_mux4_pkg.sv | 6 +
 rtl/rr_arb4.sv | 25 ++
 rtl/rr_mux4.sv | 86 ++++++++
 tb/tb_rr_mux4.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux4_pkg.sv
// rr_mux4_pkg: shared channel count, default data width and channel index type
package rr_mux4_pkg;
    localparam int NUM_CH    = 4;
    localparam int DEF_WIDTH = 8;
    typedef logic [1:0] sel_t;
endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: 4-way round-robin grant search starting at ptr_i
module rr_arb4
    import rr_mux4_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  sel_t              ptr_i,
    input  logic              en_i,
    output logic [NUM_CH-1:0] gnt_o,
    output sel_t              idx_o,
    output logic              any_o
);
    // Scan from the farthest offset down so the offset closest to ptr_i wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (en_i && req_i[sel_t'(ptr_i + sel_t'(k))]) begin
                idx_o = sel_t'(ptr_i + sel_t'(k));
                gnt_o = NUM_CH'(1) << idx_o;
                any_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_mux4.sv
// rr_mux4: 4-to-1 round-robin mux into a one-entry output register.
// Define RR_MUX4_PARITY_EN to add the registered even-parity output o_par.
module rr_mux4
    import rr_mux4_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       i_valid,
    input  logic [NUM_CH*WIDTH-1:0] i_data,
    output logic [NUM_CH-1:0]       i_ready,
`ifdef RR_MUX4_PARITY_EN
    output logic                    o_par,
`endif
    output logic                    o_valid,
    output logic [WIDTH-1:0]        o_data,
    output sel_t                    o_sel,
    input  logic                    o_ready
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    sel_t             sel_q, sel_d, ptr_q, ptr_d, gnt_idx;
    logic             any_gnt, load;
    logic [WIDTH-1:0] ch [NUM_CH];

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        assign ch[n] = i_data[n*WIDTH +: WIDTH];
    end

    assign load = !valid_q || o_ready;

    // Gating with rst keeps i_ready low while reset is held.
    rr_arb4 u_arb (
        .req_i (i_valid),
        .ptr_i (ptr_q),
        .en_i  (load && !rst),
        .gnt_o (i_ready),
        .idx_o (gnt_idx),
        .any_o (any_gnt)
    );

    // A grant replaces the register; an empty loadable cycle only drops valid.
    always_comb begin
        valid_d = any_gnt ? 1'b1 : (load ? 1'b0 : valid_q);
        data_d  = any_gnt ? ch[gnt_idx] : data_q;
        sel_d   = any_gnt ? gnt_idx : sel_q;
        ptr_d   = any_gnt ? sel_t'(gnt_idx + 2'd1) : ptr_q;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef RR_MUX4_PARITY_EN
    logic par_q, par_d;

    // Parity is computed on the incoming word so it stays aligned with o_data.
    always_comb begin
        par_d = any_gnt ? ^ch[gnt_idx] : par_q;
    end

    // Parity register, loaded alongside the data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_d;
    end

    assign o_par = par_q;
`endif

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_sel   = sel_q;
endmodule

// File: tb/tb_rr_mux4.sv
// tb_rr_mux4: directed bench for rr_mux4
module tb_rr_mux4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  i_valid = '0;
    logic [31:0] i_data = '0;
    logic [3:0]  i_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic [1:0]  o_sel;
    logic        o_ready = 1'b0;
`ifdef RR_MUX4_PARITY_EN
    logic        o_par;
`endif
    int errors = 0;
    int checks = 0;

    rr_mux4 #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_ready (i_ready),
`ifdef RR_MUX4_PARITY_EN
        .o_par   (o_par),
`endif
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sel   (o_sel),
        .o_ready (o_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        i_valid = '0;
        o_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        i_valid = 4'b1111;
        i_data = 32'h44332211;
        o_ready = 1'b1;
        #2;
        checks++;
        if (i_ready !== 4'b0000) begin errors++; $display("FAIL reset_i_ready got=%b exp=0000", i_ready); end
        tick();
        checks++;
        if ({o_valid, o_sel, o_data} !== 11'h000) begin errors++; $display("FAIL reset_out got v=%b sel=%0d data=%h exp 0/0/00", o_valid, o_sel, o_data); end
        checks++;
        if (i_ready !== 4'b0000) begin errors++; $display("FAIL reset_i_ready_held got=%b exp=0000", i_ready); end
`ifdef RR_MUX4_PARITY_EN
        checks++;
        if (o_par !== 1'b0) begin errors++; $display("FAIL reset_par got=%b exp=0", o_par); end
`endif
        rst = 1'b0;
        i_valid = '0;
        #1;
    endtask

    task automatic test_single;
        i_valid = 4'b0100;
        i_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        o_ready = 1'b1;
        #1;
        checks++;
        if (i_ready !== 4'b0100) begin errors++; $display("FAIL single_i_ready got=%b exp=0100", i_ready); end
        tick();
        i_valid = '0;
        checks++;
        if ({o_valid, o_sel, o_data} !== {1'b1, 2'd2, 8'hA5}) begin errors++; $display("FAIL single_out got v=%b sel=%0d data=%h exp 1/2/a5", o_valid, o_sel, o_data); end
        tick();
        checks++;
        if ({o_valid, o_sel, o_data} !== {1'b0, 2'd2, 8'hA5}) begin errors++; $display("FAIL idle_hold got v=%b sel=%0d data=%h exp 0/2/a5", o_valid, o_sel, o_data); end
    endtask

    task automatic test_round_robin;
        logic [7:0] exp_d [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
        do_reset();
        i_valid = 4'b1111;
        i_data = {8'h43, 8'h32, 8'h21, 8'h10};
        o_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (i_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_i_ready[%0d] got=%b exp=%b", k, i_ready, 4'b0001 << (k % 4)); end
            tick();
            checks++;
            if ({o_valid, o_sel, o_data} !== {1'b1, 2'(k % 4), exp_d[k % 4]}) begin errors++; $display("FAIL rr_out[%0d] got v=%b sel=%0d data=%h exp 1/%0d/%h", k, o_valid, o_sel, o_data, k % 4, exp_d[k % 4]); end
        end
        i_valid = '0;
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        i_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        i_valid = 4'b0001;
        o_ready = 1'b0;
        #1;
        checks++;
        if (i_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_i_ready got=%b exp=0001", i_ready); end
        tick();
        i_valid = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (i_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_i_ready[%0d] got=%b exp=0000", k, i_ready); end
            tick();
            checks++;
            if ({o_valid, o_sel, o_data} !== {1'b1, 2'd0, 8'hA0}) begin errors++; $display("FAIL bp_hold[%0d] got v=%b sel=%0d data=%h exp 1/0/a0", k, o_valid, o_sel, o_data); end
        end
        o_ready = 1'b1;
        #1;
        checks++;
        if (i_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_i_ready got=%b exp=0010", i_ready); end
        tick();
        checks++;
        if ({o_valid, o_sel, o_data} !== {1'b1, 2'd1, 8'hB1}) begin errors++; $display("FAIL bp_ch1 got v=%b sel=%0d data=%h exp 1/1/b1", o_valid, o_sel, o_data); end
        checks++;
        if (i_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_i_ready got=%b exp=1000", i_ready); end
        tick();
        checks++;
        if ({o_valid, o_sel, o_data} !== {1'b1, 2'd3, 8'hD3}) begin errors++; $display("FAIL bp_ch3 got v=%b sel=%0d data=%h exp 1/3/d3", o_valid, o_sel, o_data); end
        i_valid = '0;
        tick();
        checks++;
        if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b exp 0", o_valid); end
    endtask

    task automatic test_wrap;
        do_reset();
        i_data = {8'h3C, 8'h2C, 8'h1C, 8'h0C};
        o_ready = 1'b1;
        i_valid = 4'b0100;
        tick();
        i_valid = 4'b1000;
        #1;
        checks++;
        if (i_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ch3_i_ready got=%b exp=1000", i_ready); end
        tick();
        checks++;
        if ({o_valid, o_sel, o_data} !== {1'b1, 2'd3, 8'h3C}) begin errors++; $display("FAIL wrap_ch3 got v=%b sel=%0d data=%h exp 1/3/3c", o_valid, o_sel, o_data); end
        i_valid = 4'b0001;
        #1;
        checks++;
        if (i_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ch0_i_ready got=%b exp=0001", i_ready); end
        tick();
        checks++;
        if ({o_valid, o_sel, o_data} !== {1'b1, 2'd0, 8'h0C}) begin errors++; $display("FAIL wrap_ch0 got v=%b sel=%0d data=%h exp 1/0/0c", o_valid, o_sel, o_data); end
        i_valid = 4'b1111;
        #1;
        checks++;
        if (i_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ptr1_i_ready got=%b exp=0010", i_ready); end
        tick();
        i_valid = '0;
        tick();
    endtask

    task automatic test_async_reset;
        i_data = {8'h99, 8'h88, 8'h77, 8'h66};
        o_ready = 1'b0;
        i_valid = 4'b0100;
        tick();
        checks++;
        if ({o_valid, o_sel, o_data} !== {1'b1, 2'd2, 8'h88}) begin errors++; $display("FAIL ar_loaded got v=%b sel=%0d data=%h exp 1/2/88", o_valid, o_sel, o_data); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_sel, o_data} !== 11'h000) begin errors++; $display("FAIL ar_immediate got v=%b sel=%0d data=%h exp 0/0/00", o_valid, o_sel, o_data); end
        checks++;
        if (i_ready !== 4'b0000) begin errors++; $display("FAIL ar_i_ready got=%b exp=0000", i_ready); end
        @(negedge clk);
        rst = 1'b0;
        i_valid = 4'b1111;
        o_ready = 1'b1;
        #1;
        checks++;
        if (i_ready !== 4'b0001) begin errors++; $display("FAIL ar_first_i_ready got=%b exp=0001", i_ready); end
        @(posedge clk);
        #1;
        checks++;
        if ({o_valid, o_sel, o_data} !== {1'b1, 2'd0, 8'h66}) begin errors++; $display("FAIL ar_first_grant got v=%b sel=%0d data=%h exp 1/0/66", o_valid, o_sel, o_data); end
        i_valid = '0;
        tick();
    endtask

`ifdef RR_MUX4_PARITY_EN
    task automatic test_parity;
        do_reset();
        i_data = {8'h00, 8'h00, 8'h03, 8'h07};
        o_ready = 1'b1;
        i_valid = 4'b0011;
        tick();
        checks++;
        if ({o_data, o_par} !== {8'h07, 1'b1}) begin errors++; $display("FAIL par_07 got data=%h par=%b exp 07/1", o_data, o_par); end
        tick();
        checks++;
        if ({o_data, o_par} !== {8'h03, 1'b0}) begin errors++; $display("FAIL par_03 got data=%h par=%b exp 03/0", o_data, o_par); end
        i_valid = '0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_async_reset();
`ifdef RR_MUX4_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
